fifo16_wr_arbiter: RTL
======================

# fifo16_wr_arbiter

Two-port round-robin write arbiter that shares the single write port of a 16-deep × 16-bit FIFO between two producers. It sequences each write as issue, then check-acknowledge. It retries writes that the FIFO rejects and respects the FIFO full flag. It keeps saturating per-producer accepted-word counters and a retry counter for software visibility. It sits between producer blocks and the FIFO's `write`, `d_in`, `full`, `wr_ack` and `wr_err` pins. It never drives the FIFO read side.

## Interface
Parameters:
- `DATA_W`, 16, data width of producer words and FIFO `d_in`.
- `CNT_W`, 8, width of the accepted-word and retry counters.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1 each  producer write request; held high until the matching `done`.
- `d0`, `d1`  in  `DATA_W` each  producer data; stable while the matching `req` is high.
- `gnt0`, `gnt1`  out  1 each  grant; high in ISSUE and WAIT for the selected producer.
- `done0`, `done1`  out  1 each  one-cycle pulse; the word was accepted by the FIFO.
- `fifo_write`  out  1  FIFO write strobe.
- `fifo_d_in`  out  `DATA_W`  FIFO write data.
- `fifo_full`  in  1  FIFO full flag.
- `fifo_wr_ack`  in  1  FIFO write-acknowledge flag. It reflects the action at the previous clock edge.
- `fifo_wr_err`  in  1  FIFO write-error flag. It reflects the action at the previous clock edge.
- `cnt_clr`  in  1  synchronous clear of all three counters.
- `acc_cnt0`, `acc_cnt1`  out  `CNT_W` each  saturating count of accepted words per producer.
- `retry_cnt`  out  `CNT_W`  saturating count of `fifo_wr_err` retries.

## Operation
- FSM states: IDLE, ISSUE, WAIT. Encoding is 2 bits; the unused code returns to IDLE.
- **IDLE**
  - A producer is eligible when its `req` is high and `fifo_full` is 0.
  - If none is eligible, stay in IDLE.
  - If exactly one is eligible, grant it.
  - If both are eligible, grant the producer selected by the priority pointer `prio` (0 selects producer 0).
  - On a grant, latch the granted `dX` into `fifo_d_in`, record the owner, and go to ISSUE.
- **ISSUE**
  - `fifo_write` is 1 for exactly this one cycle.
  - `fifo_d_in` holds the latched word.
  - Next state is WAIT unconditionally.
- **WAIT**
  - Sample the FIFO flags.
  - `fifo_wr_ack`=1:
    - `doneX` = 1 combinationally for the owner.
    - Increment `acc_cntX`.
    - Set `prio` to the non-owner.
    - Go to IDLE.
  - `fifo_wr_err`=1:
    - No `done`.
    - Increment `retry_cnt`.
    - `prio` is unchanged.
    - Go to IDLE; the same producer re-arbitrates, and the word is re-latched from `dX`.
  - Neither flag set: treat as error; same handling as `fifo_wr_err`.
- `fifo_write` and `gnt` are decoded from the state and owner registers only. They carry no combinational path from inputs.
- `done` is Mealy: WAIT & owner & `fifo_wr_ack`. A producer that registers `done` updates `req`/`d` at the same edge, so IDLE sees fresh values.
- If `req` is dropped while granted, the latched word is still written, and `done` still pulses.
- `fifo_full` is checked only in IDLE. A full condition arising later is reported by `fifo_wr_err` and handled as a retry.
- Counters:
  - Width `CNT_W`, unsigned.
  - Saturate at 2^`CNT_W`−1 and never wrap.
  - `cnt_clr` takes priority over an increment in the same cycle.
- Reset values, applied asynchronously:
  - state IDLE, `prio`=0, owner=0.
  - `fifo_d_in`=0, `fifo_write`=0.
  - `gnt0`=`gnt1`=0, `done0`=`done1`=0.
  - all counters 0.

## Timing
- Request-to-write latency: `req` high in cycle T (IDLE, not full) → `fifo_write`=1 in T+1 → ack sampled and `done` pulsed in T+2 → IDLE in T+3.
- Peak throughput is one word per 3 cycles.
- Producer alternation under contention: words come from 0, 1, 0, 1, … Each producer waits at most one competing transaction plus its own retries.
- `fifo_write` never asserts in two consecutive cycles.
- Reset asserted mid-ISSUE drops `fifo_write` immediately. A partially issued write may or may not land; no `done` is produced.
- Deassertion of `rst_n` is synchronous to `clk` upstream of this block.

## Test plan
- Reset: hold `rst_n`=0 with `req0`=1 → all outputs 0. Release → `gnt0` in cycle 1, `fifo_write`=1 with `fifo_d_in`=`d0` in cycle 1, `done0` in cycle 2, `acc_cnt0`=1.
- Contention: `req0`=`req1`=1 continuously, `d0`=16'hA5A5, `d1`=16'h5A5A, FIFO model 16 deep → FIFO receives A5A5, 5A5A, A5A5, 5A5A…; after 16 writes `fifo_full`=1 and no further `fifo_write`; `acc_cnt0`=`acc_cnt1`=8.
- Retry: model forces `fifo_wr_err`=1 on the first write by producer 1 → no `done1`, `retry_cnt`=1, `prio` unchanged, producer 1 re-granted; second attempt acks → `done1` once, `acc_cnt1`=1.
- Saturation: CNT_W=8, 300 accepted writes from producer 0 with the FIFO drained by the bench → `acc_cnt0`=255. `cnt_clr` pulsed in the same cycle as an ack → `acc_cnt0`=0.
- Request drop: `req1` pulsed for one cycle with `d1`=16'h1234 → FIFO receives 1234 and `done1` pulses once; no second grant follows.
- Reset mid-op: assert `rst_n`=0 during ISSUE → `fifo_write` falls in the same cycle, state is IDLE and counters are 0 after release, and the next grant goes to producer 0.

Source files
------------

// File: rtl/fifo16_wr_arbiter.sv
// fifo16_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port between two producers.
//   Each write is issued for one cycle, then the FIFO's ack/err flags are
//   checked in the following cycle; rejected words are re-arbitrated and
//   re-latched from the producer. Saturating counters track accepted words
//   per producer and retries.
// Ports
//   clk, rst_n         clock, async active-low reset
//   req0/1, d0/1       producer request + data (held until matching done)
//   gnt0/1             owner of the in-flight write (ISSUE/WAIT)
//   done0/1            one-cycle pulse: word accepted by the FIFO
//   fifo_write/d_in    FIFO write strobe and data
//   fifo_full          FIFO full flag (checked only when arbitrating)
//   fifo_wr_ack/err    FIFO result of the previous edge's write
//   cnt_clr            synchronous clear of all counters
//   acc_cnt0/1         saturating accepted-word counters
//   retry_cnt          saturating retry counter

// Saturating up-counter with synchronous clear (clear wins over increment).
module fifo16_wr_arbiter_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != {W{1'b1}}))
            q <= q + 1'b1;
    end
endmodule

module fifo16_wr_arbiter #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] d0,
    input  logic [DATA_W-1:0] d1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              fifo_write,
    output logic [DATA_W-1:0] fifo_d_in,
    input  logic              fifo_full,
    input  logic              fifo_wr_ack,
    input  logic              fifo_wr_err,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  acc_cnt0,
    output logic [CNT_W-1:0]  acc_cnt1,
    output logic [CNT_W-1:0]  retry_cnt
);
    localparam int NUM_PROD = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   prio_q, prio_d;
    logic   lat_en;
    logic   sel;
    logic [NUM_PROD-1:0] elig;

    logic [NUM_PROD-1:0]             req;
    logic [NUM_PROD-1:0][DATA_W-1:0] din;
    logic [NUM_PROD-1:0]             gnt;
    logic [NUM_PROD-1:0]             done;
    logic [NUM_PROD-1:0][CNT_W-1:0]  acc;
    logic                            in_wait;
    logic                            retry_inc;

    assign req = {req1, req0};
    assign din = {d1, d0};

    // Next-state / arbitration
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        lat_en  = 1'b0;
        sel     = 1'b0;
        elig    = req & {NUM_PROD{~fifo_full}};
        case (state_q)
            IDLE: begin
                if (elig == 2'b11)
                    sel = prio_q;
                else
                    sel = elig[1];
                if (|elig) begin
                    lat_en  = 1'b1;
                    owner_d = sel;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                state_d = IDLE;
                // Only an ack moves the pointer; an error or a missing ack
                // lets the same owner win again.
                if (fifo_wr_ack)
                    prio_d = ~owner_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b0;
            prio_q    <= 1'b0;
            fifo_d_in <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            if (lat_en)
                fifo_d_in <= din[sel];
        end
    end

    // Strobe and grants come from registers only; done is Mealy on the ack.
    assign in_wait    = (state_q == WAIT);
    assign fifo_write = (state_q == ISSUE);
    assign retry_inc  = in_wait & ~fifo_wr_ack;

    genvar i;
    generate
        for (i = 0; i < NUM_PROD; i++) begin : g_prod
            assign gnt[i]  = ((state_q == ISSUE) || in_wait) && (owner_q == i[0]);
            assign done[i] = in_wait && (owner_q == i[0]) && fifo_wr_ack;

            fifo16_wr_arbiter_cnt #(.W(CNT_W)) u_acc (
                .clk   (clk),
                .rst_n (rst_n),
                .clr   (cnt_clr),
                .inc   (done[i]),
                .q     (acc[i])
            );
        end
    endgenerate

    fifo16_wr_arbiter_cnt #(.W(CNT_W)) u_retry (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (retry_inc),
        .q     (retry_cnt)
    );

    assign gnt0     = gnt[0];
    assign gnt1     = gnt[1];
    assign done0    = done[0];
    assign done1    = done[1];
    assign acc_cnt0 = acc[0];
    assign acc_cnt1 = acc[1];
endmodule
